// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the PC, requests words from the I-cache
// and queues them in a small in-order FIFO for the IF/ID latch.
module fetch_queue_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          QDEPTH  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc,
  output logic [31:0] fetch_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic          halted;
  logic          push;
  logic          pop;
  logic          flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nx;
  end

  // Halt is sticky: only reset leaves HALTED.
  always_comb begin
    state_nx = state;
    halted   = 1'b0;
    unique case (state)
      RUN:     if (halt) state_nx = HALTED;
      HALTED:  halted = 1'b1;
      default: state_nx = RUN;
    endcase
  end

  assign flush = redirect | halt;

  always_comb begin
    iREN = !RST && !halted && !redirect
        && (count < FULL);
    instr_valid = (count != '0) && !redirect
               && !halted;
    push = iREN && ihit && !halt;
    pop  = instr_valid && id_ready;
  end

  assign iaddr     = pc;
  assign instr     = q_instr[rd_ptr];
  assign instr_pc  = q_pc[rd_ptr];
  assign instr_npc = instr_pc + 32'd4;

  // Slots are cleared on reset so the stale head reads as zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= PC_INIT;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (pop) fetch_cnt <= fetch_cnt + 32'd1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (redirect) pc <= redirect_pc;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= iload;
          q_pc[wr_ptr]    <= pc;
          wr_ptr          <= wr_ptr + PW'(1);
          pc              <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

endmodule
